// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the memory-mapped IO bus controller:
//   - controller state encoding
//   - well-known peripheral slot indices
//   - default populated / acknowledging slot masks
//   - register offsets of the optional error-status slot
// No ports (package).
// -----------------------------------------------------------------------------
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int SLOT_BASIC_IO = 0;
  localparam int SLOT_KEYPAD   = 1;
  localparam int SLOT_SOUND    = 2;
  localparam int SLOT_VGATERM  = 3;
  localparam int SLOT_PS2      = 4;

  localparam logic [15:0] DEF_PRESENT_MASK = 16'h001F;
  localparam logic [15:0] DEF_ACK_MASK     = 16'h0018;

  localparam logic [7:0] ERR_OFS_STATUS = 8'h00;
  localparam logic [7:0] ERR_OFS_SLOT   = 8'h01;
  localparam logic [7:0] ERR_OFS_OFFSET = 8'h02;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mmio_timeout_ctr
// Loadable saturating up-counter used to bound how long the controller waits
// for a slot acknowledge. A load restarts the count at 1; increments stop at
// MAX so the terminal count stays asserted once reached.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count clears to 0)
//   load   in   restart the count at 1 (has priority over inc)
//   inc    in   advance the count by one, saturating at MAX
//   tc     out  terminal count: count has reached MAX
// -----------------------------------------------------------------------------
module mmio_timeout_ctr #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam logic [15:0] MAX_C = 16'(MAX);

  logic [15:0] cnt_q, cnt_d;

  // Next-count selection: load, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 16'd1;
    end else if (inc && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q >= MAX_C);

endmodule

// File: rtl/mmio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_bus_ctrl
// Decodes a CPU IO access into one of NSLOTS peripheral slots, issues a
// registered one-hot select with a single-cycle read or write strobe, and
// stalls the CPU until the slot acknowledges. Slots without an acknowledge
// line complete one cycle after the strobe. Unpopulated slots and slots that
// do not acknowledge within TIMEOUT cycles end with a one-cycle bus_err and
// all-ones read data.
// Optional build macro MMIO_ERR_STATUS_EN: slot NSLOTS-1 becomes an internal
// error-status slot (offset 0 flags, 1 faulting slot, 2 faulting offset;
// any write to offset 0 clears the flags).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   re, we, addr        CPU request (held while cpu_stall), IO address
//   data_write          CPU write data
//   data_read           latched read data
//   cpu_stall           CPU wait (combinational)
//   bus_err             one-cycle pulse on unmapped / timed-out access
//   per_sel             registered one-hot slot select
//   per_re, per_we      one-cycle read / write strobes
//   per_addr, per_wdata registered register offset and write data
//   per_rdata           flattened slot read data, slot n at [n*DW +: DW]
//   per_ack             slot acknowledge, read data valid in the same cycle
// -----------------------------------------------------------------------------
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                NSLOTS       = 16,
  parameter int                ABITS        = 12,
  parameter int                DW           = 8,
  parameter logic [NSLOTS-1:0] PRESENT_MASK = DEF_PRESENT_MASK,
  parameter logic [NSLOTS-1:0] ACK_MASK     = DEF_ACK_MASK,
  parameter int unsigned       TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 re,
  input  logic                 we,
  input  logic [ABITS-1:0]     addr,
  input  logic [DW-1:0]        data_write,
  output logic [DW-1:0]        data_read,
  output logic                 cpu_stall,
  output logic                 bus_err,
  output logic [NSLOTS-1:0]    per_sel,
  output logic                 per_re,
  output logic                 per_we,
  output logic [7:0]           per_addr,
  output logic [DW-1:0]        per_wdata,
  input  logic [NSLOTS*DW-1:0] per_rdata,
  input  logic [NSLOTS-1:0]    per_ack
);

  localparam int SW = ABITS - 8;

  // The status slot is always present, internally answered and never selected
  // on the external bus.
`ifdef MMIO_ERR_STATUS_EN
  localparam logic [NSLOTS-1:0] STAT_BIT = {1'b1, {(NSLOTS-1){1'b0}}};
`else
  localparam logic [NSLOTS-1:0] STAT_BIT = '0;
`endif
  localparam logic [NSLOTS-1:0] PRESENT_EFF = PRESENT_MASK | STAT_BIT;
  localparam logic [NSLOTS-1:0] ACK_EFF     = ACK_MASK & ~STAT_BIT;

  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [7:0]          ofs_q, ofs_d;
  logic                wr_q, wr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [NSLOTS-1:0]   sel_q, sel_d;
  logic                re_q, re_d, we_q, we_d, err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d, rd_mux;
  logic                ctr_load, ctr_inc, ctr_tc;
  logic [SW-1:0]       req_slot;

  assign req_slot = addr[ABITS-1:8];

  mmio_timeout_ctr #(.MAX(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .tc    (ctr_tc)
  );

`ifdef MMIO_ERR_STATUS_EN
  logic          sticky_q, sticky_d, to_flag_q, to_flag_d, um_flag_q, um_flag_d;
  logic [SW-1:0] fslot_q, fslot_d;
  logic [7:0]    fofs_q, fofs_d;
  logic          fault_um, fault_to, stat_clr;

  assign fault_um = (state_q == ST_IDLE) && (re | we) && !PRESENT_EFF[req_slot];
  assign fault_to = (state_q == ST_WAIT) && !per_ack[slot_q] && ctr_tc;
  assign stat_clr = (state_q == ST_STROBE) && wr_q && STAT_BIT[slot_q] &&
                    (ofs_q == ERR_OFS_STATUS);

  // Error-status update: the type flags describe the most recent fault only,
  // while the sticky bit remembers that any fault occurred since the last clear.
  always_comb begin
    sticky_d  = sticky_q;
    to_flag_d = to_flag_q;
    um_flag_d = um_flag_q;
    fslot_d   = fslot_q;
    fofs_d    = fofs_q;
    if (fault_um) begin
      sticky_d  = 1'b1;
      to_flag_d = 1'b0;
      um_flag_d = 1'b1;
      fslot_d   = req_slot;
      fofs_d    = addr[7:0];
    end else if (fault_to) begin
      sticky_d  = 1'b1;
      to_flag_d = 1'b1;
      um_flag_d = 1'b0;
      fslot_d   = slot_q;
      fofs_d    = ofs_q;
    end else if (stat_clr) begin
      sticky_d  = 1'b0;
      to_flag_d = 1'b0;
      um_flag_d = 1'b0;
    end else begin
      sticky_d  = sticky_q;
      to_flag_d = to_flag_q;
      um_flag_d = um_flag_q;
    end
  end

  // Error-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      to_flag_q <= 1'b0;
      um_flag_q <= 1'b0;
      fslot_q   <= '0;
      fofs_q    <= 8'h00;
    end else begin
      sticky_q  <= sticky_d;
      to_flag_q <= to_flag_d;
      um_flag_q <= um_flag_d;
      fslot_q   <= fslot_d;
      fofs_q    <= fofs_d;
    end
  end

  // Read-data source: internal status registers or the selected slot's bus.
  always_comb begin
    rd_mux = per_rdata[int'(slot_q)*DW +: DW];
    if (STAT_BIT[slot_q]) begin
      case (ofs_q)
        ERR_OFS_STATUS: begin
          rd_mux = '0;
          rd_mux[DW-1 -: 3] = {sticky_q, to_flag_q, um_flag_q};
        end
        ERR_OFS_SLOT:   rd_mux = DW'(fslot_q);
        ERR_OFS_OFFSET: rd_mux = DW'(fofs_q);
        default:        rd_mux = '0;
      endcase
    end else begin
      rd_mux = per_rdata[int'(slot_q)*DW +: DW];
    end
  end
`else
  // Read-data source: the selected slot's bus.
  always_comb begin
    rd_mux = per_rdata[int'(slot_q)*DW +: DW];
  end
`endif

  // Access sequencer: next state, latched request and registered bus outputs.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ofs_d    = ofs_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (re | we) begin
          slot_d  = req_slot;
          ofs_d   = addr[7:0];
          wr_d    = we;          // simultaneous re/we is a write
          wdata_d = data_write;
          if (!PRESENT_EFF[req_slot]) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (!we) begin
              rdata_d = '1;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
            state_d = ST_STROBE;
            sel_d   = '0;
            if (!STAT_BIT[req_slot]) begin
              sel_d[req_slot] = 1'b1;
              re_d = ~we;
              we_d = we;
            end else begin
              re_d = 1'b0;
              we_d = 1'b0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (!ACK_EFF[slot_q] || per_ack[slot_q]) begin
          state_d = ST_DONE;
          sel_d   = '0;
          if (!wr_q) begin
            rdata_d = rd_mux;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d  = ST_WAIT;
          ctr_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (per_ack[slot_q]) begin
          state_d = ST_DONE;
          sel_d   = '0;
          if (!wr_q) begin
            rdata_d = rd_mux;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (ctr_tc) begin
          state_d = ST_DONE;
          sel_d   = '0;
          err_d   = 1'b1;
          if (!wr_q) begin
            rdata_d = '1;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          ctr_inc = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      ofs_q   <= 8'h00;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ofs_q   <= ofs_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_stall = (re | we) & (state_q != ST_DONE);
  assign data_read = rdata_q;
  assign bus_err   = err_q;
  assign per_sel   = sel_q;
  assign per_re    = re_q;
  assign per_we    = we_q;
  assign per_addr  = ofs_q;
  assign per_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_bus_ctrl
// Scoreboard bench for mmio_bus_ctrl (TIMEOUT=8, default slot masks). Each
// access pushes its expected outcome; the outcome observed when the stall
// drops is popped and compared. Status-slot accesses run only when
// MMIO_ERR_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_mmio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         re = 1'b0, we = 1'b0;
  logic [11:0]  addr = 12'h000;
  logic [7:0]   data_write = 8'h00;
  logic [7:0]   data_read;
  logic         cpu_stall, bus_err, per_re, per_we;
  logic [15:0]  per_sel;
  logic [7:0]   per_addr, per_wdata;
  logic [127:0] per_rdata;
  logic [15:0]  per_ack = 16'h0000;
  logic [7:0]   rd_tab [16];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  rd;
    logic        err;
    int          stall;
    int          nre;
    int          nwe;
    logic [15:0] sel;
    logic [7:0]  paddr;
    logic [7:0]  pwdata;
    int          gap;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  always_comb begin
    per_rdata = '0;
    for (int i = 0; i < 16; i++) per_rdata[i*8 +: 8] = rd_tab[i];
  end

  mmio_bus_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr),
    .data_write(data_write), .data_read(data_read), .cpu_stall(cpu_stall),
    .bus_err(bus_err), .per_sel(per_sel), .per_re(per_re), .per_we(per_we),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata),
    .per_ack(per_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One CPU access. ack_dly: cycles after the strobe to pulse per_ack (<0 never).
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [11:0] a, input logic [7:0] wd, input int ack_dly,
                        input logic [7:0] e_rd, input logic e_err, input int e_stall,
                        input logic [15:0] e_sel, input int e_gap);
    exp_t e, g;
    int cyc = 0, stall_n = 0, nre = 0, nwe = 0, err_n = 0, strobe_cyc = -1, err_cyc = -1;
    logic [15:0] sel_or = 16'h0000;
    logic [7:0] paddr_s = 8'h00, pwdata_s = 8'h00, rd_s = 8'h00;
    bit done = 1'b0;
    e.rd = e_rd; e.err = e_err; e.stall = e_stall; e.sel = e_sel;
    e.nre = (e_sel != 16'h0000 && r && !w) ? 1 : 0;
    e.nwe = (e_sel != 16'h0000 && w) ? 1 : 0;
    e.paddr = a[7:0]; e.pwdata = wd; e.gap = e_gap;
    sb_q.push_back(e);
    @(posedge clk); #1;
    re = r; we = w; addr = a; data_write = wd;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_stall) stall_n++;
      if (per_re) nre++;
      if (per_we) nwe++;
      if (per_re | per_we) begin strobe_cyc = cyc; paddr_s = per_addr; pwdata_s = per_wdata; end
      sel_or |= per_sel;
      if (bus_err) begin err_n++; err_cyc = cyc; end
      if (!cpu_stall) begin done = 1'b1; rd_s = data_read; end
      if (ack_dly >= 0 && strobe_cyc >= 0 && cyc - strobe_cyc == ack_dly)
        per_ack = 16'h0001 << a[11:8];
      else
        per_ack = 16'h0000;
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0; per_ack = 16'h0000;
    @(negedge clk);
    if (bus_err) err_n++;
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_eq({tag, "_rd"}, 32'(rd_s), 32'(g.rd));
      check_eq({tag, "_err"}, 32'(err_n), 32'(g.err));
      check_eq({tag, "_stall"}, 32'(stall_n), 32'(g.stall));
      check_eq({tag, "_sel"}, 32'(sel_or), 32'(g.sel));
      check_eq({tag, "_nre"}, 32'(nre), 32'(g.nre));
      check_eq({tag, "_nwe"}, 32'(nwe), 32'(g.nwe));
      if (g.nre + g.nwe > 0) check_eq({tag, "_paddr"}, 32'(paddr_s), 32'(g.paddr));
      if (g.nwe > 0) check_eq({tag, "_pwdata"}, 32'(pwdata_s), 32'(g.pwdata));
      if (g.gap >= 0) check_eq({tag, "_errgap"}, 32'(err_cyc - strobe_cyc), 32'(g.gap));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd"},     32'(data_read), 32'd0);
    check_eq({tag, "_stall"},  32'(cpu_stall), 32'd0);
    check_eq({tag, "_err"},    32'(bus_err),   32'd0);
    check_eq({tag, "_sel"},    32'(per_sel),   32'd0);
    check_eq({tag, "_re"},     32'(per_re),    32'd0);
    check_eq({tag, "_we"},     32'(per_we),    32'd0);
    check_eq({tag, "_paddr"},  32'(per_addr),  32'd0);
    check_eq({tag, "_pwdata"}, 32'(per_wdata), 32'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    for (int i = 0; i < 16; i++) rd_tab[i] = 8'(i * 17);
    rd_tab[0] = 8'hA5; rd_tab[1] = 8'h5A; rd_tab[3] = 8'hC3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    access("t1_rd0",   1'b1, 1'b0, 12'h005, 8'h00,  -1, 8'hA5, 1'b0,  2, 16'h0001, -1);
    access("t2_wr3",   1'b0, 1'b1, 12'h310, 8'h3C,   4, 8'hA5, 1'b0,  6, 16'h0008, -1);
    access("t3_um9",   1'b1, 1'b0, 12'h900, 8'h00,  -1, 8'hFF, 1'b1,  1, 16'h0000, -1);
    access("t4_to4",   1'b1, 1'b0, 12'h420, 8'h00,  -1, 8'hFF, 1'b1, 10, 16'h0010,  9);
    access("t4_next",  1'b1, 1'b0, 12'h107, 8'h00,  -1, 8'h5A, 1'b0,  2, 16'h0002, -1);
`ifdef MMIO_ERR_STATUS_EN
    access("t6_st0",   1'b1, 1'b0, 12'hF00, 8'h00,  -1, 8'hC0, 1'b0,  2, 16'h0000, -1);
    access("t6_st1",   1'b1, 1'b0, 12'hF01, 8'h00,  -1, 8'h04, 1'b0,  2, 16'h0000, -1);
    access("t6_st2",   1'b1, 1'b0, 12'hF02, 8'h00,  -1, 8'h20, 1'b0,  2, 16'h0000, -1);
    access("t6_clr",   1'b0, 1'b1, 12'hF00, 8'h5B,  -1, 8'h20, 1'b0,  2, 16'h0000, -1);
    access("t6_st0b",  1'b1, 1'b0, 12'hF00, 8'h00,  -1, 8'h00, 1'b0,  2, 16'h0000, -1);
`endif
    access("ack0_rd3", 1'b1, 1'b0, 12'h3FE, 8'h00,   0, 8'hC3, 1'b0,  2, 16'h0008, -1);
    access("t5_rw2",   1'b1, 1'b1, 12'h233, 8'h77,  -1, 8'hC3, 1'b0,  2, 16'h0004, -1);
    access("um_wrA",   1'b0, 1'b1, 12'hA11, 8'h99,  -1, 8'hC3, 1'b1,  1, 16'h0000, -1);

    // Reset asserted while waiting on a slot that never acknowledges.
    @(posedge clk); #1;
    re = 1'b1; addr = 12'h300;
    cyc = 0;
    while (!per_re && cyc < 20) begin @(negedge clk); cyc++; end
    check_eq("rst_strobe_seen", 32'(per_re), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("rst_in_wait_sel", 32'(per_sel), 32'h0008);
    rst_n = 1'b0; re = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_err || per_re || per_we || per_sel != 16'h0000) bad++;
    end
    check_eq("rst_quiet", 32'(bad), 32'd0);
    access("post_rst", 1'b1, 1'b0, 12'h0AB, 8'h00,  -1, 8'hA5, 1'b0,  2, 16'h0001, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised memory-mapped IO bus controller: the next generation of the peripheral decode/read-latch block. Decodes a CPU IO address into one of NSLOTS peripheral slots, drives a registered one-hot select with single-cycle read/write strobes, and stalls the CPU until the slot acknowledges. Fixed-latency slots use an implied acknowledge. Unmapped or hung slots are terminated by a timeout with a bus error. Sits between the AVR core IO port and the peripheral instances (basic IO, keypad, sound, vgaterm, ps2, …).

Parameters:
NSLOTS, 16, number of peripheral slots; slot index = addr[ABITS-1:8].
ABITS, 12, CPU IO address width; register offset is always addr[7:0].
DW, 8, data width.
PRESENT_MASK, 16'h001F, bit n set = slot n is populated.
ACK_MASK, 16'h0018, bit n set = slot n drives per_ack; clear = implied ack one cycle after strobe.
TIMEOUT, 255, maximum cycles to wait for per_ack; valid range 1..65535.

Ports:
clk  in  1  CPU clock
rst_n  in  1  asynchronous active-low reset
re  in  1  CPU read request, held while cpu_stall=1
we  in  1  CPU write request, held while cpu_stall=1
addr  in  ABITS  CPU IO address
data_write  in  DW  CPU write data
data_read  out  DW  latched read data
cpu_stall  out  1  CPU wait
bus_err  out  1  one-cycle pulse on an unmapped or timed-out access
per_sel  out  NSLOTS  registered one-hot slot select
per_re  out  1  read strobe, one cycle
per_we  out  1  write strobe, one cycle
per_addr  out  8  registered register offset
per_wdata  out  DW  registered write data
per_rdata  in  NSLOTS*DW  flattened slot read data; slot n occupies [n*DW +: DW]
per_ack  in  NSLOTS  slot acknowledge, read data valid in the same cycle

Behaviour:
- Reset: all outputs are 0, including data_read. State goes to IDLE, the timeout counter clears, and the latched slot, offset and wdata clear. Reset asserted mid-transaction abandons the access, with no strobe or error afterwards.
- States: IDLE, STROBE, WAIT, DONE.
- cpu_stall = (re|we) & (state != DONE). This is combinational, so the request cycle itself stalls.
- IDLE, on re|we:
  - Latch slot, offset, direction and data_write.
  - If re and we are both high, the access is a write.
  - If the slot is unpopulated (PRESENT_MASK bit clear): go to DONE, pulse bus_err in DONE, and load data_read with all-ones on a read. No per_sel and no strobe are issued.
  - Otherwise go to STROBE.
- STROBE (exactly one cycle):
  - per_sel[slot]=1; per_re or per_we=1.
  - Implied-ack slot: on a read, capture per_rdata[slot] at the end of this cycle, then go to DONE.
  - Ack slot: if per_ack[slot]=1, capture and go to DONE; else go to WAIT and load the counter with 1.
- WAIT:
  - per_sel held; strobes low.
  - per_ack[slot]=1: capture on a read, then go to DONE.
  - Counter reaches TIMEOUT: go to DONE, pulse bus_err, and load data_read with all-ones on a read.
  - Counter saturates; per_ack of non-selected slots is ignored.
- DONE (one cycle): per_sel=0, stall released, return to IDLE. A request held into IDLE is treated as a new access.
- Latency: an implied-ack read has stall high for 2 cycles and data_read valid in the DONE cycle (request cycle + 2). A write does not change data_read.
- data_read holds its last value between reads.

Optional Feature:
MMIO_ERR_STATUS_EN:
- When defined, slot NSLOTS-1 is an internal error-status slot (it overrides PRESENT_MASK and has implied ack).
- Offset 0 reads {sticky_err, timeout_flag, unmapped_flag, 5'b0}. Offset 1 reads the last faulting slot index. Offset 2 reads the last faulting offset.
- Any write to offset 0 clears the flags.
- When not defined, no status registers exist; bus_err is the only error indication and slot NSLOTS-1 follows PRESENT_MASK.

Decomposition:
- Package mmio_pkg holds:
  - the state encoding;
  - slot index constants (BASIC_IO=0, KEYPAD=1, SOUND=2, VGATERM=3, PS2=4);
  - the default PRESENT_MASK and ACK_MASK;
  - the error-status offsets.
- One natural sub-module, mmio_timeout_ctr: loadable saturating counter with a terminal-count output.

Test Plan:
1. Read of slot 0 (implied ack), addr=12'h005, per_rdata slot0=8'hA5 -> per_sel=16'h0001 with per_re for one cycle; cpu_stall high 2 cycles; data_read=8'hA5 at request+2; bus_err=0.
2. Write to slot 3 (ack), addr=12'h310, data 8'h3C, per_ack asserted 4 cycles after strobe -> per_we one cycle; per_wdata=8'h3C and per_addr=8'h10; stall released in the DONE cycle; data_read unchanged.
3. Read of unpopulated slot 9 -> no per_sel and no strobe; bus_err pulse; data_read=8'hFF; stall high for 1 cycle only.
4. Ack slot 4 never acks, TIMEOUT=8 -> bus_err exactly 8 cycles after entering WAIT; data_read=8'hFF; return to IDLE; the next access completes normally.
5. re and we both high to slot 2 -> write strobe only. Separately, rst_n asserted during WAIT -> all outputs 0 immediately and no later bus_err.
6. With MMIO_ERR_STATUS_EN: after the timeout in test 4, read 12'hF00 -> 8'hC0 and 12'hF01 -> 8'h04; write 12'hF00, then re-read -> 8'h00.
